// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

    localparam int unsigned DATA_W_MIN = 5;
    localparam int unsigned DATA_W_MAX = 9;
    localparam int unsigned DIV_MIN    = 1;

    // Parity over a zero-extended data word; odd=1 selects odd parity.
    function automatic logic parity_bit(input logic [DATA_W_MAX-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/level; head word is always visible.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [LVL_W-1:0] level_nxt;

    // Qualify handshakes and compute the next occupancy.
    always_comb begin
        do_push   = push && !full;
        do_pop    = pop && !empty;
        level_nxt = level + LVL_W'(do_push) - LVL_W'(do_pop);
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and status flags, all derived from the same next level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_nxt;
            full  <= (level_nxt == LVL_W'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter: write FIFO, runtime baud divisor, optional parity, 1/2 stop bits.
module uart_tx_fifo_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DIV_W  = 16
) (
    input  logic                     clk,
    input  logic                     RSTn,
    input  logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_en,
    input  logic [DIV_W-1:0]         baud_div,
    input  logic                     parity_en,
    input  logic                     parity_odd,
    input  logic                     two_stop,
    output logic                     TXD,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     ovf
);

    localparam int unsigned BIT_W = $clog2(DATA_W);

    uart_tx_state_t    state;
    logic [DATA_W-1:0] fifo_head;
    logic [DATA_W-1:0] shreg;
    logic [DIV_W-1:0]  baud_cnt;
    logic [DIV_W-1:0]  frame_div;
    logic [DIV_W-1:0]  eff_div_c;
    logic [BIT_W-1:0]  bit_idx;
    logic              par_bit;
    logic              f_par_en;
    logic              f_two_stop;
    logic              stop_idx;
    logic              tick_c;
    logic              last_stop_c;
    logic              pop_c;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (RSTn),
        .push      (tx_en),
        .push_data (tx_data),
        .pop       (pop_c),
        .head      (fifo_head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // Bit-boundary detect and pop decision (from IDLE, or straight out of the last stop bit).
    always_comb begin
        eff_div_c   = (baud_div == '0) ? DIV_W'(DIV_MIN) : baud_div;
        tick_c      = (baud_cnt == frame_div);
        last_stop_c = !f_two_stop || stop_idx;
        pop_c       = !empty && ((state == ST_IDLE) ||
                                 ((state == ST_STOP) && tick_c && last_stop_c));
    end

    // Frame FSM with baud counter; frame config is captured at pop time.
    always_ff @(posedge clk) begin
        if (!RSTn) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            frame_div  <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            f_par_en   <= 1'b0;
            f_two_stop <= 1'b0;
            stop_idx   <= 1'b0;
        end else if (pop_c) begin
            shreg      <= fifo_head;
            par_bit    <= parity_bit(DATA_W_MAX'(fifo_head), parity_odd);
            f_par_en   <= parity_en;
            f_two_stop <= two_stop;
            frame_div  <= eff_div_c;
            baud_cnt   <= '0;
            state      <= ST_START;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                end
                ST_START: begin
                    if (tick_c) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + DIV_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_c) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (bit_idx == BIT_W'(DATA_W - 1)) begin
                            stop_idx <= 1'b0;
                            state    <= f_par_en ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + DIV_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (tick_c) begin
                        baud_cnt <= '0;
                        stop_idx <= 1'b0;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + DIV_W'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_c) begin
                        baud_cnt <= '0;
                        if (!last_stop_c) begin
                            stop_idx <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered line, busy and overflow outputs, one cycle behind the FSM state.
    always_ff @(posedge clk) begin
        if (!RSTn) begin
            TXD  <= 1'b1;
            busy <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            ovf  <= tx_en && full;
            busy <= (state != ST_IDLE);
            case (state)
                ST_START:  TXD <= 1'b0;
                ST_DATA:   TXD <= shreg[0];
                ST_PARITY: TXD <= par_bit;
                default:   TXD <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Scoreboard bench: three transmitters (DATA_W 8, 5, 9) share stimulus; per-instance
// monitors decode TXD against queued expected frames.
module tb_uart_tx_fifo_cfg;

    typedef struct {
        logic [8:0] data;
        bit         par_en;
        bit         par_odd;
        bit         two_stop;
        int         period;
        int         start_cyc;
        bit         b2b;
    } frame_t;

    logic        clk;
    logic        rst_n;
    logic [8:0]  tx_data;
    logic        tx_en;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        two_stop;

    logic        txd_v   [3];
    logic        full_v  [3];
    logic        empty_v [3];
    logic        busy_v  [3];
    logic        ovf_v   [3];
    logic [4:0]  level_v [3];

    frame_t exp_q [3][$];
    int     last_end [3];
    int     cyc = 0;
    int     total = 0;
    int     passed = 0;
    bit     mon_en = 0;
    bit     mon_off = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int unsigned DW = (gi == 0) ? 8 : ((gi == 1) ? 5 : 9);

        uart_tx_fifo_cfg #(
            .DATA_W (DW),
            .DEPTH  (16),
            .DIV_W  (16)
        ) u_dut (
            .clk        (clk),
            .RSTn       (rst_n),
            .tx_data    (tx_data[DW-1:0]),
            .tx_en      (tx_en),
            .baud_div   (baud_div),
            .parity_en  (parity_en),
            .parity_odd (parity_odd),
            .two_stop   (two_stop),
            .TXD        (txd_v[gi]),
            .full       (full_v[gi]),
            .empty      (empty_v[gi]),
            .level      (level_v[gi]),
            .busy       (busy_v[gi]),
            .ovf        (ovf_v[gi])
        );

        // Monitor: on a start bit, pop the expected frame and check every cycle of every bit.
        initial begin : mon
            frame_t     e;
            logic       seq [$];
            logic       p;
            logic [1:0] got;
            forever begin
                @(negedge clk);
                if (mon_en && !mon_off && txd_v[gi] === 1'b0) begin
                    if (exp_q[gi].size() == 0) begin
                        total++;
                        $display("FAIL unexpected_frame inst%0d: got start bit expected idle line (cycle %0d)", gi, cyc);
                        repeat (40) @(negedge clk);
                    end else begin
                        e = exp_q[gi].pop_front();
                        if (e.start_cyc >= 0)
                            check($sformatf("inst%0d_start_latency", gi), 32'(cyc), 32'(e.start_cyc));
                        if (e.b2b)
                            check($sformatf("inst%0d_no_gap", gi), 32'(cyc), 32'(last_end[gi]));
                        seq.delete();
                        seq.push_back(1'b0);
                        p = e.par_odd;
                        for (int j = 0; j < int'(DW); j++) begin
                            seq.push_back(e.data[j]);
                            p = p ^ e.data[j];
                        end
                        if (e.par_en) seq.push_back(p);
                        seq.push_back(1'b1);
                        if (e.two_stop) seq.push_back(1'b1);
                        for (int b = 0; b < seq.size(); b++) begin
                            got = {1'b1, seq[b]};
                            for (int k = 0; k < e.period; k++) begin
                                if (b != 0 || k != 0) @(negedge clk);
                                if ((txd_v[gi] !== seq[b] || busy_v[gi] !== 1'b1) && got == {1'b1, seq[b]})
                                    got = {busy_v[gi], txd_v[gi]};
                            end
                            check($sformatf("inst%0d_data%0h_bit%0d_busy_txd", gi, e.data, b),
                                  32'(got), 32'({1'b1, seq[b]}));
                        end
                        last_end[gi] = cyc + 1;
                    end
                end
            end
        end
    end

    // Drive one word (caller is at a negedge) and queue its expected frame on every instance.
    task automatic put_word(input logic [8:0] d, input bit chk_lat, input bit b2b);
        frame_t e;
        tx_data    = d;
        tx_en      = 1'b1;
        e.data     = d;
        e.par_en   = parity_en;
        e.par_odd  = parity_odd;
        e.two_stop = two_stop;
        e.period   = (baud_div == 16'd0) ? 2 : int'(baud_div) + 1;
        e.start_cyc = chk_lat ? cyc + 3 : -1;
        e.b2b      = b2b;
        for (int i = 0; i < 3; i++) exp_q[i].push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0 &&
                     busy_v[0] === 1'b0 && busy_v[1] === 1'b0 && busy_v[2] === 1'b0) && n < 5000);
        check("drain_within_budget", 32'(n < 5000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lowseen;
        rst_n      = 1'b0;
        tx_en      = 1'b0;
        tx_data    = '0;
        baud_div   = 16'd3;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_txd",   32'(txd_v[0]),   32'd1);
        check("rst_full",  32'(full_v[0]),  32'd0);
        check("rst_empty", 32'(empty_v[0]), 32'd1);
        check("rst_level", 32'(level_v[0]), 32'd0);
        check("rst_busy",  32'(busy_v[0]),  32'd0);
        check("rst_ovf",   32'(ovf_v[0]),   32'd0);
        check("rst_txd_w9", 32'(txd_v[2]),  32'd1);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame: 0xA5, 4-cycle bits, no parity, one stop
        put_word(9'h0A5, 1'b1, 1'b0);
        @(negedge clk);
        tx_en = 1'b0;
        check("level_after_single_write", 32'(level_v[0]), 32'd1);
        wait_idle();

        // Even parity + two stops, then odd parity
        parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b1;
        @(negedge clk);
        put_word(9'h007, 1'b1, 1'b0);
        @(negedge clk);
        tx_en = 1'b0;
        wait_idle();
        parity_odd = 1'b1;
        put_word(9'h007, 1'b1, 1'b0);
        @(negedge clk);
        tx_en = 1'b0;
        wait_idle();

        // Back-to-back: level 1,1,2 then three gapless frames
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0; baud_div = 16'd1;
        @(negedge clk);
        put_word(9'h011, 1'b1, 1'b0);
        @(negedge clk);
        check("b2b_level_1", 32'(level_v[0]), 32'd1);
        put_word(9'h022, 1'b0, 1'b1);
        @(negedge clk);
        check("b2b_level_2", 32'(level_v[0]), 32'd1);
        put_word(9'h033, 1'b0, 1'b1);
        @(negedge clk);
        tx_en = 1'b0;
        check("b2b_level_3", 32'(level_v[0]), 32'd2);
        wait_idle();
        check("b2b_empty_after", 32'(empty_v[0]), 32'd1);
        check("b2b_level_after", 32'(level_v[0]), 32'd0);

        // Divisor 0 behaves as 1 (2-cycle bits)
        baud_div = 16'd0;
        put_word(9'h03C, 1'b1, 1'b0);
        @(negedge clk);
        tx_en = 1'b0;
        wait_idle();

        // Overflow: 17 writes fill the FIFO, the 18th is dropped
        baud_div = 16'd1; parity_en = 1'b1; two_stop = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 17; i++) begin
            if (i > 1) begin
                check($sformatf("ovf_level_after_w%0d", i - 1), 32'(level_v[0]), 32'((i == 2) ? 1 : i - 2));
                check($sformatf("ovf_full_after_w%0d", i - 1), 32'(full_v[0]), 32'd0);
            end
            put_word(9'(i * 23), (i == 1), (i > 1));
            @(negedge clk);
        end
        check("ovf_level_full", 32'(level_v[0]), 32'd16);
        check("ovf_full_set",   32'(full_v[0]),  32'd1);
        tx_data = 9'h1FF;
        tx_en   = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        check("ovf_pulse",       32'(ovf_v[0]),   32'd1);
        check("ovf_pulse_w5",    32'(ovf_v[1]),   32'd1);
        check("ovf_level_kept",  32'(level_v[0]), 32'd16);
        @(negedge clk);
        check("ovf_one_cycle",   32'(ovf_v[0]),   32'd0);
        wait_idle();

        // Mid-frame config change only affects the next frame
        parity_en = 1'b0; two_stop = 1'b0; baud_div = 16'd2;
        @(negedge clk);
        put_word(9'h05A, 1'b1, 1'b0);
        @(negedge clk);
        tx_en = 1'b0;
        repeat (10) @(negedge clk);
        baud_div  = 16'd5;
        parity_en = 1'b1;
        put_word(9'h0C3, 1'b0, 1'b1);
        @(negedge clk);
        tx_en = 1'b0;
        wait_idle();

        // Nine-bit words with odd parity; narrower instances see masked data
        parity_odd = 1'b1; baud_div = 16'd2;
        @(negedge clk);
        put_word(9'h1A5, 1'b1, 1'b0);
        @(negedge clk);
        put_word(9'h0F3, 1'b0, 1'b1);
        @(negedge clk);
        tx_en = 1'b0;
        wait_idle();

        // Reset mid-frame aborts and flushes the FIFO
        parity_en = 1'b0; parity_odd = 1'b0; baud_div = 16'd3;
        mon_off = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_data = 9'(8'h61 + i);
            tx_en   = 1'b1;
            @(negedge clk);
        end
        tx_en = 1'b0;
        repeat (12) @(negedge clk);
        check("pre_reset_busy", 32'(busy_v[0]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_txd",   32'(txd_v[0]),   32'd1);
        check("midrst_level", 32'(level_v[0]), 32'd0);
        check("midrst_busy",  32'(busy_v[0]),  32'd0);
        check("midrst_empty", 32'(empty_v[0]), 32'd1);
        rst_n = 1'b1;
        lowseen = 0;
        repeat (300) begin
            @(negedge clk);
            if (txd_v[0] !== 1'b1 || txd_v[1] !== 1'b1 || txd_v[2] !== 1'b1) lowseen++;
        end
        check("no_frame_after_reset", 32'(lowseen), 32'd0);
        mon_off = 1'b0;

        for (int i = 0; i < 3; i++)
            check($sformatf("inst%0d_queue_empty", i), 32'(exp_q[i].size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
